// File: rtl/data_memory_responder_if.sv
// Core-side data bus plus console/status outputs of the data memory responder.
// The master modport is the core (and console sink); the slave modport is the responder.
interface data_memory_responder_if #(
    parameter int XLEN = 32
);
    logic            memory_write_enable;
    logic [XLEN-1:0] memory_address;
    logic [XLEN-1:0] memory_write_data;
    logic [XLEN-1:0] memory_read_data;
    logic            console_valid;
    logic [7:0]      console_data;
    logic            console_ready;
    logic            halt;
    logic [XLEN-1:0] halt_code;
    logic [XLEN-1:0] gpio_out;
    logic            error;

    modport master (
        output memory_write_enable, memory_address, memory_write_data, console_ready,
        input  memory_read_data, console_valid, console_data, halt, halt_code, gpio_out, error
    );

    modport slave (
        input  memory_write_enable, memory_address, memory_write_data, console_ready,
        output memory_read_data, console_valid, console_data, halt, halt_code, gpio_out, error
    );
endinterface

// File: rtl/data_memory_responder.sv
// Zero-latency data memory for a single-cycle core: word RAM plus a 16-byte MMIO
// window holding a console FIFO, a TOHOST halt register, a cycle counter and GPIO.
module data_memory_responder #(
    parameter int              XLEN        = 32,
    parameter int              DEPTH_WORDS = 1024,
    parameter logic [XLEN-1:0] MMIO_BASE   = 'h1000_0000,
    parameter int              FIFO_DEPTH  = 8
) (
    input  logic                    clk,
    input  logic                    n_rst,
    data_memory_responder_if.slave  bus
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        REG_CONSOLE = 2'd0,
        REG_TOHOST  = 2'd1,
        REG_CYCLE   = 2'd2,
        REG_GPIO    = 2'd3
    } mmio_reg_e;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic            aligned;
    logic            ram_hit;
    logic            mmio_hit;
    mmio_reg_e       mmio_reg;
    logic [AW-1:0]   word_idx;
    logic            store;
    logic            ram_we;
    logic            mmio_we;
    logic            bad_store;

    assign aligned  = (bus.memory_address[1:0] == 2'b00);
    assign ram_hit  = (bus.memory_address[XLEN-1:AW+2] == '0);
    assign mmio_hit = (bus.memory_address[XLEN-1:4] == MMIO_BASE[XLEN-1:4]);
    assign mmio_reg = mmio_reg_e'(bus.memory_address[3:2]);
    assign word_idx = bus.memory_address[AW+1:2];

    // Stores presented while reset is held are dropped entirely.
    assign store     = bus.memory_write_enable && n_rst;
    assign ram_we    = store && aligned && ram_hit;
    assign mmio_we   = store && aligned && !ram_hit && mmio_hit;
    assign bad_store = store && (!aligned || (!ram_hit && !mmio_hit));

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [XLEN-1:0] ram_mem  [DEPTH_WORDS];
    logic [7:0]      fifo_mem [FIFO_DEPTH];

    logic [PW-1:0]   rd_ptr_q,    rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q,    wr_ptr_d;
    logic [CW-1:0]   count_q,     count_d;
    logic            halt_q,      halt_d;
    logic [XLEN-1:0] halt_code_q, halt_code_d;
    logic [XLEN-1:0] cycle_q,     cycle_d;
    logic [XLEN-1:0] gpio_q,      gpio_d;
    logic            error_q,     error_d;

    logic            fifo_empty;
    logic            fifo_full;
    logic            push_req;
    logic            push;
    logic            pop;
    logic            overflow;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
    assign pop        = !fifo_empty && bus.console_ready;
    assign push_req   = mmio_we && (mmio_reg == REG_CONSOLE);
    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    assign push       = push_req && (!fifo_full || pop);
    assign overflow   = push_req && fifo_full && !pop;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        halt_d      = halt_q;
        halt_code_d = halt_code_q;
        gpio_d      = gpio_q;
        cycle_d     = cycle_q + XLEN'(1);
        error_d     = error_q | bad_store | overflow;

        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        count_d = count_q + CW'(push) - CW'(pop);

        if (mmio_we) begin
            case (mmio_reg)
                REG_TOHOST: begin
                    if (!halt_q) begin
                        halt_d      = 1'b1;
                        halt_code_d = bus.memory_write_data;
                    end
                end
                REG_GPIO:    gpio_d = bus.memory_write_data;
                REG_CONSOLE,
                REG_CYCLE:   ;
            endcase
        end
    end

    // NOTE: sequential state is written only with non-blocking assignments so every
    // register samples the pre-edge values, independent of process ordering.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            halt_q      <= 1'b0;
            halt_code_q <= '0;
            cycle_q     <= '0;
            gpio_q      <= '0;
            error_q     <= 1'b0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            halt_q      <= halt_d;
            halt_code_q <= halt_code_d;
            cycle_q     <= cycle_d;
            gpio_q      <= gpio_d;
            error_q     <= error_d;
        end
    end

    // NOTE: storage arrays carry no reset; contents are only meaningful once written,
    // and leaving them unreset lets them map onto RAM macros.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram_mem[word_idx] <= bus.memory_write_data;
        end
        if (push) begin
            fifo_mem[wr_ptr_q] <= bus.memory_write_data[7:0];
        end
    end

    // ------------------------------------------------------------------
    // Combinational read path
    // ------------------------------------------------------------------
    logic [XLEN-1:0] read_data;

    always_comb begin
        read_data = '0;
        if (aligned) begin
            if (ram_hit) begin
                read_data = ram_mem[word_idx];
            end else if (mmio_hit) begin
                case (mmio_reg)
                    REG_CONSOLE: begin
                        read_data[15:8] = 8'(count_q);
                        read_data[0]    = fifo_full;
                    end
                    REG_TOHOST: read_data = halt_code_q;
                    REG_CYCLE:  read_data = cycle_q;
                    REG_GPIO:   read_data = gpio_q;
                endcase
            end
        end
    end

    assign bus.memory_read_data = read_data;
    assign bus.console_valid    = !fifo_empty;
    assign bus.console_data     = fifo_mem[rd_ptr_q];
    assign bus.halt             = halt_q;
    assign bus.halt_code        = halt_code_q;
    assign bus.gpio_out         = gpio_q;
    assign bus.error            = error_q;

    // ------------------------------------------------------------------
    // Invariants
    // ------------------------------------------------------------------
    a_count_range: assert property (@(posedge clk) disable iff (!n_rst)
        count_q <= CW'(FIFO_DEPTH));

    a_error_sticky: assert property (@(posedge clk) disable iff (!n_rst)
        error_q |=> error_q);

    a_head_stable: assert property (@(posedge clk) disable iff (!n_rst)
        (bus.console_valid && !bus.console_ready) |=> $stable(bus.console_data));

endmodule

// File: doc/data_memory_responder.md
DATA_MEMORY_RESPONDER -- requirements
Module: data_memory_responder

Interface
REQ-001 SHALL have parameter XLEN, default 32, data/address width.
REQ-002 SHALL have parameter DEPTH_WORDS, default 1024, RAM size in words (power of two).
REQ-003 SHALL have parameter MMIO_BASE, default 32'h1000_0000, base of MMIO window (16 bytes).
REQ-004 SHALL have parameter FIFO_DEPTH, default 8, console FIFO entries (power of two).
REQ-005 SHALL have port clk input 1, clock; all state updates on posedge.
REQ-006 SHALL have port n_rst input 1, reset, synchronous, active-low.
REQ-007 SHALL have port memory_write_enable input 1, store request from core this cycle.
REQ-008 SHALL have port memory_address input XLEN, byte address from core.
REQ-009 SHALL have port memory_write_data input XLEN, store data.
REQ-010 SHALL have port memory_read_data output XLEN, combinational read data for memory_address.
REQ-011 SHALL have port console_valid output 1, console FIFO non-empty.
REQ-012 SHALL have port console_data output 8, FIFO head byte.
REQ-013 SHALL have port console_ready input 1, sink accepts head when console_valid=1.
REQ-014 SHALL have port halt output 1, program wrote TOHOST.
REQ-015 SHALL have port halt_code output XLEN, value written to TOHOST.
REQ-016 SHALL have port gpio_out output XLEN, GPIO register.
REQ-017 SHALL have port error output 1, sticky access/overflow error.

Function
REQ-018 SHALL map RAM at byte addresses 0 .. DEPTH_WORDS*4-1, word index = memory_address[log2(DEPTH_WORDS)+1:2].
REQ-019 SHALL map MMIO: +0x0 CONSOLE, +0x4 TOHOST, +0x8 CYCLE, +0xC GPIO; all other addresses unmapped.
REQ-020 SHALL return read data combinationally in the same cycle (zero latency), matching the single-cycle core.
REQ-021 SHALL commit writes at the posedge following a cycle with memory_write_enable=1; a read of the same address in that cycle returns the old value.
REQ-022 SHALL ignore writes with memory_address[1:0]!=0 or to unmapped addresses and set error.
REQ-023 SHALL return 0 on reads of unmapped or misaligned addresses.
REQ-024 CONSOLE write SHALL push memory_write_data[7:0]; CONSOLE read SHALL return {count in bits [15:8], full in bit 0}, other bits 0.
REQ-025 Push when full and no pop in the same cycle SHALL drop the byte and set error.
REQ-026 Push and pop in the same cycle SHALL both occur, including when full (count unchanged) and when empty-to-one (pop not possible; push only).
REQ-027 Pop SHALL occur when console_valid && console_ready; console_data SHALL be stable while console_valid && !console_ready.
REQ-028 FIFO pointers SHALL wrap modulo FIFO_DEPTH; count range 0..FIFO_DEPTH.
REQ-029 First TOHOST write SHALL set halt=1 and halt_code=data in the next cycle; later TOHOST writes SHALL be ignored until reset; TOHOST read returns halt_code.
REQ-030 CYCLE SHALL be a free-running XLEN-bit counter incrementing every cycle, wrapping 2^XLEN-1 -> 0; writes to it ignored (no error).
REQ-031 GPIO SHALL be read/write; gpio_out reflects the register.
REQ-032 error SHALL stay 1 once set until reset.

Reset
REQ-033 On n_rst=0 at posedge: FIFO empty, console_valid=0, halt=0, halt_code=0, gpio_out=0, CYCLE=0, error=0.
REQ-034 RAM contents SHALL NOT be cleared by reset; stores in a reset cycle SHALL be discarded.
REQ-035 Reset mid-drain SHALL empty FIFO; bytes not yet popped are lost.

Verification
REQ-036 Store 0xDEADBEEF to 0x10, read 0x10 next cycle -> 0xDEADBEEF; read in the store cycle -> old value.
REQ-037 Push 9 bytes 0x41.. with console_ready=0, FIFO_DEPTH=8 -> count=8, full=1, 9th dropped, error=1; then ready=1 -> 0x41..0x48 in order.
REQ-038 FIFO full, push 0x5A with console_ready=1 same cycle -> count stays 8, error=0, 0x5A drained last.
REQ-039 Store 7 to MMIO_BASE+4 then 9 -> halt=1 next cycle, halt_code=7 persists.
REQ-040 Store to 0x13 or 0x2000_0000 -> no RAM/MMIO change, error=1, reads of those addresses return 0.
REQ-041 Release reset, read MMIO_BASE+8 after 5 cycles -> 5; assert reset -> 0, FIFO empty, RAM retains data.
